ic2rt_hit_queue: RTL and testbench
==================================

// Module: ic2rt_hit_queue
// PURPOSE
//  Return path of the IC memory: the IC cores push hit records (sid, intersection point, normal) and each RT interface pops them.
//  Counterpart of the RT->IC ray queue; replaces the single shared shader_info/normal bus with one FIFO per RT core.
//  A round-robin arbiter admits at most one IC push per cycle. Each RT core pops its own FIFO independently.
// PARAMETERS
//  NUM_IC  16  number of IC cores (producers)
//  NUM_RT   4  number of RT cores (consumers); BIT_RT = $clog2(NUM_RT), min width 1
//  DEPTH    8  entries per RT FIFO; power of 2, >= 2; BIT_D = $clog2(DEPTH)
// PORTS
//  clk            in   1              clock
//  rst_n          in   1              synchronous reset, active low
//  push_req       in   NUM_IC         IC i holds a hit record
//  push_dst       in   NUM_IC*BIT_RT  destination RT id of IC i (slice i)
//  push_shader    in   NUM_IC*128     {sid, IntersectionPoint[95:0]} of IC i
//  push_normal    in   NUM_IC*96      normal of IC i
//  push_gnt       out  NUM_IC         one-hot; record of IC i is taken this cycle
//  pop            in   NUM_RT         RT j consumes its head entry
//  valid          out  NUM_RT         FIFO j is non-empty
//  head_shader    out  NUM_RT*128     head entry of FIFO j (slice j)
//  head_normal    out  NUM_RT*96      head entry of FIFO j (slice j)
//  count          out  NUM_RT*(BIT_D+1)  occupancy of FIFO j
// BEHAVIOUR
//  Reset (rst_n low at a clk edge): all FIFOs empty, pointers and count 0, valid 0, arbiter pointer = 0.
//   Head outputs read 0 while empty; push_gnt is 0.
//   Reset mid-operation discards all entries; a grant in the same cycle is lost.
//  Eligibility: IC i is eligible iff push_req[i] && count[push_dst[i]] < DEPTH.
//   The full check uses the registered count, so a pop in the same cycle does NOT free a slot for a push.
//  Arbiter: round-robin. Search starts at rr_ptr and wraps modulo NUM_IC.
//   The first eligible IC gets push_gnt, combinationally in the same cycle.
//   On a grant, rr_ptr <= granted index + 1, wrapping to 0. With no grant, rr_ptr is held.
//   A requester whose destination is full is skipped and does not block others.
//  Producer handshake: the IC holds push_req and data until it sees push_gnt high, then drops or changes the record the next cycle.
//  push_dst >= NUM_RT: the request is never eligible and is never granted (software error).
//  Write: on a grant, the entry is written at wr_ptr[dst]; wr_ptr wraps modulo DEPTH.
//  FIFO output: first-word-fall-through from registered storage.
//   A push into an empty FIFO shows valid=1 and the head data in the cycle after the grant.
//  Pop: if pop[j] && valid[j], rd_ptr[j] advances and wraps. If pop[j] && !valid[j], nothing happens.
//  Simultaneous push and pop on the same FIFO (not full): count is unchanged, both pointers advance.
//   When count==1 the new entry becomes head the next cycle.
//  count[j] update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
//  Latency: push_req to push_gnt is 0 cycles if uncontended. Grant to valid is 1 cycle. Pop to next head is 1 cycle.
//  Throughput: 1 push per cycle in total; NUM_RT pops per cycle.
// CONFIGURATION
//  HIT_Q_STATS_EN defined: adds two ports.
//   hwm    out  NUM_RT*(BIT_D+1)  per-FIFO high-water mark of count.
//   err    out  NUM_RT            sticky flag, set by a pop on an empty FIFO.
//   Both are cleared only by reset.
//  HIT_Q_STATS_EN undefined: these ports and their registers do not exist. Functional behaviour is otherwise identical.
// TESTING
//  1 Single path: IC3 pushes sid=0x11 to dst 2 -> push_gnt[3] same cycle; valid[2]=1 next cycle, head sid=0x11; pop -> valid 0.
//  2 Fairness: IC0, IC5 and IC15 all request dst 0 every cycle from reset -> grants in order 0,5,15,0,5,15; no starvation.
//  3 Full: 8 pushes to dst 1 with no pop -> count=8, 9th request not granted.
//   Then pop and request in the same cycle -> no grant that cycle, grant the next cycle.
//  4 Skip: dst 1 full; IC2 requests dst 1 and IC4 requests dst 3 -> IC4 granted, IC2 stalls with no gnt.
//  5 Wrap and order: 20 pushes and pops interleaved on dst 0 (values 0..19) -> popped in order 0..19; count never exceeds 8.
//  6 Reset mid-run: 3 entries queued in each FIFO, rst_n low for 1 cycle -> all valid 0, count 0.
//   A stats build also shows hwm 0 and err 0. Empty pop under HIT_Q_STATS_EN -> err[j]=1, held until reset.

Source files
------------

// File: rtl/ic2rt_hit_queue.sv
// IC->RT hit-record return queue: round-robin admission of one IC push per cycle into per-RT FWFT FIFOs.
// Optional HIT_Q_STATS_EN adds per-FIFO high-water mark (hwm) and sticky empty-pop error (err) ports.
package ic2rt_hit_queue_pkg;
  localparam int unsigned SHADER_W = 128;
  localparam int unsigned NORMAL_W = 96;

  typedef struct packed {
    logic [SHADER_W-1:0] shader;
    logic [NORMAL_W-1:0] normal;
  } hit_rec_t;
endpackage

module ic2rt_hit_queue
  import ic2rt_hit_queue_pkg::*;
#(
  parameter  int unsigned NUM_IC = 16,
  parameter  int unsigned NUM_RT = 4,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned BIT_RT = (NUM_RT > 1) ? $clog2(NUM_RT) : 1,
  localparam int unsigned BIT_D  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = BIT_D + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IC-1:0]            push_req,
  input  logic [NUM_IC*BIT_RT-1:0]     push_dst,
  input  logic [NUM_IC*SHADER_W-1:0]   push_shader,
  input  logic [NUM_IC*NORMAL_W-1:0]   push_normal,
  output logic [NUM_IC-1:0]            push_gnt,
  input  logic [NUM_RT-1:0]            pop,
  output logic [NUM_RT-1:0]            valid,
  output logic [NUM_RT*SHADER_W-1:0]   head_shader,
  output logic [NUM_RT*NORMAL_W-1:0]   head_normal,
`ifdef HIT_Q_STATS_EN
  output logic [NUM_RT*CNT_W-1:0]      count,
  output logic [NUM_RT*CNT_W-1:0]      hwm,
  output logic [NUM_RT-1:0]            err
`else
  output logic [NUM_RT*CNT_W-1:0]      count
`endif
);

  localparam int unsigned BIT_IC = (NUM_IC > 1) ? $clog2(NUM_IC) : 1;

  hit_rec_t          r_mem    [NUM_RT][DEPTH];
  logic [BIT_D-1:0]  r_wr_ptr [NUM_RT];
  logic [BIT_D-1:0]  r_rd_ptr [NUM_RT];
  logic [CNT_W-1:0]  r_cnt    [NUM_RT];
  logic [BIT_IC-1:0] r_rr_ptr;

  logic [BIT_RT-1:0] w_dst     [NUM_IC];
  logic [NUM_IC-1:0] w_elig;
  logic [NUM_RT-1:0] w_full;
  logic              w_gnt_vld;
  logic [BIT_IC-1:0] w_gnt_idx;
  logic [BIT_RT-1:0] w_gnt_dst;
  hit_rec_t          w_push_data;
  logic [NUM_RT-1:0] w_push;
  logic [NUM_RT-1:0] w_pop;
  logic [CNT_W-1:0]  w_cnt_nxt [NUM_RT];

  // Eligibility uses the registered count: a same-cycle pop never frees a slot.
  always_comb begin
    w_elig = '0;
    w_full = '0;
    for (int unsigned j = 0; j < NUM_RT; j++) begin
      w_full[j] = (r_cnt[j] == CNT_W'(DEPTH));
    end
    for (int unsigned i = 0; i < NUM_IC; i++) begin
      w_dst[i] = push_dst[i*BIT_RT +: BIT_RT];
      if (push_req[i] && (32'(w_dst[i]) < NUM_RT)) begin
        w_elig[i] = !w_full[w_dst[i]];
      end
    end
  end

  // Round-robin search starting at r_rr_ptr; grant is suppressed while in reset.
  always_comb begin
    int unsigned v_idx;
    v_idx     = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    push_gnt  = '0;
    for (int unsigned k = 0; k < NUM_IC; k++) begin
      v_idx = 32'(r_rr_ptr) + k;
      if (v_idx >= NUM_IC) begin
        v_idx = v_idx - NUM_IC;
      end
      if (!w_gnt_vld && w_elig[BIT_IC'(v_idx)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = BIT_IC'(v_idx);
      end
    end
    if (!rst_n) begin
      w_gnt_vld = 1'b0;
    end
    if (w_gnt_vld) begin
      push_gnt[w_gnt_idx] = 1'b1;
    end
  end

  assign w_gnt_dst          = w_dst[w_gnt_idx];
  assign w_push_data.shader = push_shader[w_gnt_idx*SHADER_W +: SHADER_W];
  assign w_push_data.normal = push_normal[w_gnt_idx*NORMAL_W +: NORMAL_W];

  always_comb begin
    for (int unsigned j = 0; j < NUM_RT; j++) begin
      w_push[j] = w_gnt_vld && (32'(w_gnt_dst) == j);
      w_pop[j]  = pop[j] && (r_cnt[j] != '0);
      case ({w_push[j], w_pop[j]})
        2'b10:   w_cnt_nxt[j] = r_cnt[j] + CNT_W'(1);
        2'b01:   w_cnt_nxt[j] = r_cnt[j] - CNT_W'(1);
        default: w_cnt_nxt[j] = r_cnt[j];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      for (int unsigned j = 0; j < NUM_RT; j++) begin
        r_wr_ptr[j] <= '0;
        r_rd_ptr[j] <= '0;
        r_cnt[j]    <= '0;
      end
    end else begin
      if (w_gnt_vld) begin
        r_rr_ptr <= (32'(w_gnt_idx) == NUM_IC - 1) ? '0 : w_gnt_idx + BIT_IC'(1);
      end
      for (int unsigned j = 0; j < NUM_RT; j++) begin
        if (w_push[j]) r_wr_ptr[j] <= r_wr_ptr[j] + BIT_D'(1);
        if (w_pop[j])  r_rd_ptr[j] <= r_rd_ptr[j] + BIT_D'(1);
        r_cnt[j] <= w_cnt_nxt[j];
      end
    end
  end

  // Payload storage carries no reset; empty FIFOs mask their head to zero.
  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < NUM_RT; j++) begin
      if (w_push[j]) begin
        r_mem[j][r_wr_ptr[j]] <= w_push_data;
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < NUM_RT; j++) begin
      valid[j]                            = (r_cnt[j] != '0);
      head_shader[j*SHADER_W +: SHADER_W] = valid[j] ? r_mem[j][r_rd_ptr[j]].shader : '0;
      head_normal[j*NORMAL_W +: NORMAL_W] = valid[j] ? r_mem[j][r_rd_ptr[j]].normal : '0;
      count[j*CNT_W +: CNT_W]             = r_cnt[j];
    end
  end

`ifdef HIT_Q_STATS_EN
  logic [CNT_W-1:0]  r_hwm [NUM_RT];
  logic [NUM_RT-1:0] r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= '0;
      for (int unsigned j = 0; j < NUM_RT; j++) begin
        r_hwm[j] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < NUM_RT; j++) begin
        if (w_cnt_nxt[j] > r_hwm[j]) r_hwm[j] <= w_cnt_nxt[j];
        if (pop[j] && (r_cnt[j] == '0)) r_err[j] <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < NUM_RT; j++) begin
      hwm[j*CNT_W +: CNT_W] = r_hwm[j];
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_ic2rt_hit_queue.sv
// Directed bench for ic2rt_hit_queue: single path, fairness, full/skip, ordering with wrap, reset mid-run.
// Define HIT_Q_STATS_EN for both files to also check the hwm/err statistics ports.
module tb_ic2rt_hit_queue;

  localparam int unsigned NUM_IC = 16;
  localparam int unsigned NUM_RT = 4;
  localparam int unsigned BIT_RT = 2;
  localparam int unsigned CNT_W  = 4;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_IC-1:0]          push_req;
  logic [NUM_IC*BIT_RT-1:0]   push_dst;
  logic [NUM_IC*128-1:0]      push_shader;
  logic [NUM_IC*96-1:0]       push_normal;
  logic [NUM_IC-1:0]          push_gnt;
  logic [NUM_RT-1:0]          pop;
  logic [NUM_RT-1:0]          valid;
  logic [NUM_RT*128-1:0]      head_shader;
  logic [NUM_RT*96-1:0]       head_normal;
  logic [NUM_RT*CNT_W-1:0]    count;
`ifdef HIT_Q_STATS_EN
  logic [NUM_RT*CNT_W-1:0]    hwm;
  logic [NUM_RT-1:0]          err;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_fair [6] = '{0, 5, 15, 0, 5, 15};
  int q [$];

  ic2rt_hit_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_req    (push_req),
    .push_dst    (push_dst),
    .push_shader (push_shader),
    .push_normal (push_normal),
    .push_gnt    (push_gnt),
    .pop         (pop),
    .valid       (valid),
    .head_shader (head_shader),
    .head_normal (head_normal),
`ifdef HIT_Q_STATS_EN
    .count       (count),
    .hwm         (hwm),
    .err         (err)
`else
    .count       (count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] shd(input int sid);
    return {32'(sid), 96'(sid) ^ 96'hDEAD_BEEF_0000_1234_5678_9ABC};
  endfunction

  function automatic logic [95:0] nrm(input int sid);
    return 96'(sid * 3) ^ 96'hCAFE_F00D_1111_2222_3333_4444;
  endfunction

  function automatic logic [127:0] hs(input int j);
    return head_shader[j*128 +: 128];
  endfunction

  function automatic logic [95:0] hn(input int j);
    return head_normal[j*96 +: 96];
  endfunction

  function automatic logic [CNT_W-1:0] cnt(input int j);
    return count[j*CNT_W +: CNT_W];
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int ic, input int dst, input int sid);
    push_req[ic]               = 1'b1;
    push_dst[ic*BIT_RT +: 2]   = 2'(dst);
    push_shader[ic*128 +: 128] = shd(sid);
    push_normal[ic*96 +: 96]   = nrm(sid);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; push_req = '0; push_dst = '0; push_shader = '0; push_normal = '0; pop = '0;
    tick(); tick();

    // Reset state; a request during reset must not be granted or written
    req(0, 0, 5); #1;
    chk("gnt_in_reset", 256'(push_gnt), 256'(16'h0));
    tick(); push_req = '0; rst_n = 1'b1; #1;
    chk("rst_valid", 256'(valid), 256'(4'h0));
    chk("rst_count", 256'(count), 256'(16'h0));
    chk("rst_head0", 256'(hs(0)), 256'(128'h0));

    // Pop on empty FIFOs is a no-op
    pop = 4'hF; tick(); pop = '0; #1;
    chk("empty_pop_count", 256'(count), 256'(16'h0));
`ifdef HIT_Q_STATS_EN
    chk("empty_pop_err", 256'(err), 256'(4'hF));
`endif

    // Single path: IC3 -> dst 2
    req(3, 2, 'h11); #1;
    chk("t1_gnt", 256'(push_gnt), 256'(16'h0008));
    tick(); push_req = '0; #1;
    chk("t1_valid", 256'(valid), 256'(4'b0100));
    chk("t1_head_shader", 256'(hs(2)), 256'(shd('h11)));
    chk("t1_head_normal", 256'(hn(2)), 256'(nrm('h11)));
    chk("t1_count", 256'(count), 256'(16'h0100));
    pop = 4'b0100; tick(); pop = '0; #1;
    chk("t1_valid_after_pop", 256'(valid), 256'(4'h0));
    chk("t1_head_zero", 256'(hs(2)), 256'(128'h0));

    // Fairness: IC0, IC5, IC15 all to dst 0 from reset
    do_reset();
    req(0, 0, 0); req(5, 0, 5); req(15, 0, 15);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t2_rr_gnt", 256'(push_gnt), 256'(16'b1 << exp_fair[k]));
      tick();
    end
    push_req = '0; #1;
    chk("t2_count", 256'(cnt(0)), 256'(4'd6));

    // Full: 8 pushes to dst 1, then blocked; pop does not free a slot in the same cycle
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req(1, 1, 'h20 + i); #1;
      chk("t3_fill_gnt", 256'(push_gnt), 256'(16'h0002));
      tick();
    end
    req(1, 1, 'h28); #1;
    chk("t3_count_full", 256'(cnt(1)), 256'(4'd8));
    chk("t3_full_no_gnt", 256'(push_gnt), 256'(16'h0));
    pop = 4'b0010; #1;
    chk("t3_pop_same_cycle", 256'(push_gnt), 256'(16'h0));
    tick(); pop = '0; #1;
    chk("t3_gnt_after_pop", 256'(push_gnt), 256'(16'h0002));
    chk("t3_head_next", 256'(hs(1)), 256'(shd('h21)));
    chk("t3_count_7", 256'(cnt(1)), 256'(4'd7));
    tick(); push_req = '0; #1;
    chk("t3_count_refull", 256'(cnt(1)), 256'(4'd8));

    // Skip: dst 1 full, IC2 -> dst 1 stalls, IC4 -> dst 3 granted
    req(2, 1, 'h30); req(4, 3, 'h40); #1;
    chk("t4_skip_gnt", 256'(push_gnt), 256'(16'h0010));
    tick(); push_req[4] = 1'b0; #1;
    chk("t4_stall", 256'(push_gnt), 256'(16'h0));
    tick(); push_req = '0; #1;
    chk("t4_valid", 256'(valid), 256'(4'b1010));
    chk("t4_head3", 256'(hs(3)), 256'(shd('h40)));
    chk("t4_count", 256'(count), 256'(16'h1080));

    // Wrap and order: values 0..19 through dst 0, push and pop overlapped at count 1
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      push_req = '0; pop = '0;
      if (c < 20) req(0, 0, c);
      if (c >= 1 && q.size() > 0) pop[0] = 1'b1;
      #1;
      chk("t5_count", 256'(cnt(0)), 256'(q.size()));
      if (q.size() > 0) chk("t5_head_order", 256'(hs(0)), 256'(shd(q[0])));
      if (c < 20) chk("t5_gnt", 256'(push_gnt), 256'(16'h0001));
      tick();
      if (pop[0]) void'(q.pop_front());
      if (c < 20) q.push_back(c);
    end
    push_req = '0; pop = '0; #1;
    chk("t5_drained", 256'(valid), 256'(4'h0));

    // Reset mid-run: three entries in every FIFO, then reset
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 4; j++) begin
        req(0, j, 'h50 + 4*r + j);
        tick();
      end
    end
    push_req = '0; #1;
    chk("t6_count_full", 256'(count), 256'(16'h3333));
    chk("t6_valid_full", 256'(valid), 256'(4'hF));
`ifdef HIT_Q_STATS_EN
    chk("t6_hwm", 256'(hwm), 256'(16'h3333));
`endif
    do_reset(); #1;
    chk("t6_rst_valid", 256'(valid), 256'(4'h0));
    chk("t6_rst_count", 256'(count), 256'(16'h0));
`ifdef HIT_Q_STATS_EN
    chk("t6_rst_hwm", 256'(hwm), 256'(16'h0));
    chk("t6_rst_err", 256'(err), 256'(4'h0));
`endif
    pop = 4'b0100; tick(); pop = '0; tick(); tick(); #1;
    chk("t6_empty_pop_count", 256'(count), 256'(16'h0));
`ifdef HIT_Q_STATS_EN
    chk("t6_err_sticky", 256'(err), 256'(4'b0100));
    do_reset(); #1;
    chk("t6_err_cleared", 256'(err), 256'(4'h0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
